// File: rtl/game_io_pkg.sv
// Shared game I/O definitions: debounce FSM encoding, button indices and defaults.
package game_io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_START = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int SYNC_DEFAULT     = 2;

    typedef struct packed {
        logic level;
        logic press;
        logic hold;
    } btn_out_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: synchroniser, debounce FSM with stable-time counter, press pulse
// and a sticky hold flag released by the slow-domain tick.
module btn_debounce
    import game_io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     raw,
    input  logic     tick,
    output btn_out_t out
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    btn_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   hold_q, hold_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync)                 state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = PRESSED;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A return to high is bounce on release: resume PRESSED silently.
                if (sync)                  state_d = PRESSED;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        // A press coinciding with tick must survive until the next slow edge.
        hold_d  = press_d ? 1'b1 : (tick ? 1'b0 : hold_q);
    end

    assign out.level = level_q;
    assign out.press = press_q;
    assign out.hold  = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioning: one independent debounce channel per button,
// outputs packed onto level / press / hold buses.
module button_conditioner
    import game_io_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int SYNC_STAGES     = SYNC_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_hold
);

    btn_out_t [NUM_BTN-1:0] btn_out;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk (clk),
            .rst (rst),
            .raw (btn_raw[i]),
            .tick(tick),
            .out (btn_out[i])
        );
        assign btn_level[i] = btn_out[i].level;
        assign btn_press[i] = btn_out[i].press;
        assign btn_hold[i]  = btn_out[i].hold;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected press pulses are queued when a press is
// driven and matched cycle-exactly against btn_press; level/hold checked inline.
module tb_button_conditioner;

    localparam int NB  = 3;
    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int LAT = 1 + SS + DC;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_hold;

    typedef struct {
        int            cyc;
        logic [NB-1:0] mask;
    } press_ev_t;

    press_ev_t sb[$];
    int ncyc   = 0;
    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .tick     (tick),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_hold (btn_hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    // Advance to the next falling edge and match any press pulse against the queue.
    task automatic cyc_step();
        press_ev_t ev;
        @(negedge clk);
        if (btn_press !== '0 || (sb.size() > 0 && sb[0].cyc <= ncyc)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL press_unexpected: cycle %0d got %b, required none", ncyc, btn_press);
            end else begin
                ev = sb.pop_front();
                if (ev.cyc != ncyc || btn_press !== ev.mask) begin
                    errors++;
                    $display("FAIL press_event: cycle %0d got %b, required %b at cycle %0d",
                             ncyc, btn_press, ev.mask, ev.cyc);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) cyc_step();
    endtask

    task automatic expect_press(input logic [NB-1:0] m);
        sb.push_back('{ncyc + LAT, m});
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc_step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; btn_raw = '0;
        steps(3);
        checks++;
        if ({btn_level, btn_press, btn_hold} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b, required 0", {btn_level, btn_press, btn_hold});
        end
        btn_raw = '1;
        steps(LAT + 2);
        checks++;
        if ({btn_level, btn_press, btn_hold} !== '0) begin
            errors++;
            $display("FAIL reset_hold_raw: got %b, required 0", {btn_level, btn_press, btn_hold});
        end
        btn_raw = '0;
        steps(3);
        rst = 1'b0;
        steps(2);
    endtask

    task automatic test_single_press();
        int c;
        logic [NB-1:0] exp;
        c = ncyc; btn_raw[0] = 1'b1; expect_press(3'b001);
        for (int k = 0; k < 20; k++) begin
            cyc_step();
            exp = (ncyc >= c + LAT) ? 3'b001 : 3'b000;
            checks++;
            if (btn_level !== exp) begin
                errors++;
                $display("FAIL single_level: cycle %0d got %b, required %b", ncyc, btn_level, exp);
            end
        end
        checks++;
        if (btn_hold !== 3'b001) begin
            errors++;
            $display("FAIL single_hold: got %b, required 001", btn_hold);
        end
        c = ncyc; btn_raw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc_step();
            exp = (ncyc < c + LAT) ? 3'b001 : 3'b000;
            checks++;
            if (btn_level !== exp) begin
                errors++;
                $display("FAIL release_level: cycle %0d got %b, required %b", ncyc, btn_level, exp);
            end
        end
        pulse_tick();
        checks++;
        if (btn_hold !== 3'b000) begin
            errors++;
            $display("FAIL single_hold_clear: got %b, required 000", btn_hold);
        end
    endtask

    task automatic test_bounce();
        int c;
        logic [NB-1:0] exp;
        for (int k = 0; k < 12; k++) begin
            btn_raw[1] = ((k % 4) < 2);
            cyc_step();
            checks++;
            if (btn_level !== 3'b000) begin
                errors++;
                $display("FAIL bounce_level: cycle %0d got %b, required 000", ncyc, btn_level);
            end
        end
        c = ncyc; btn_raw[1] = 1'b1; expect_press(3'b010);
        for (int k = 0; k < 12; k++) begin
            cyc_step();
            exp = (ncyc >= c + LAT) ? 3'b010 : 3'b000;
            checks++;
            if (btn_level !== exp) begin
                errors++;
                $display("FAIL bounce_settle: cycle %0d got %b, required %b", ncyc, btn_level, exp);
            end
        end
        btn_raw[1] = 1'b0;
        steps(LAT + 3);
        pulse_tick();
    endtask

    task automatic test_glitch();
        int c;
        logic [NB-1:0] exp;
        btn_raw[2] = 1'b1; expect_press(3'b100);
        steps(LAT + 3);
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) btn_raw[2] = 1'b1;
            cyc_step();
            checks++;
            if (btn_level !== 3'b100) begin
                errors++;
                $display("FAIL glitch_level: cycle %0d got %b, required 100", ncyc, btn_level);
            end
        end
        c = ncyc; btn_raw[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc_step();
            exp = (ncyc < c + LAT) ? 3'b100 : 3'b000;
            checks++;
            if (btn_level !== exp) begin
                errors++;
                $display("FAIL glitch_release: cycle %0d got %b, required %b", ncyc, btn_level, exp);
            end
        end
        pulse_tick();
    endtask

    task automatic test_hold();
        int c;
        logic [NB-1:0] exp;
        c = ncyc; btn_raw[0] = 1'b1; expect_press(3'b001);
        for (int k = 0; k < LAT + 4; k++) begin
            cyc_step();
            exp = (ncyc >= c + LAT) ? 3'b001 : 3'b000;
            checks++;
            if (btn_hold !== exp) begin
                errors++;
                $display("FAIL hold_set: cycle %0d got %b, required %b", ncyc, btn_hold, exp);
            end
        end
        pulse_tick();
        checks++;
        if (btn_hold !== 3'b000) begin
            errors++;
            $display("FAIL hold_clear: got %b, required 000", btn_hold);
        end
        btn_raw[0] = 1'b0;
        steps(LAT + 3);

        expect_press(3'b001); btn_raw[0] = 1'b1;
        steps(LAT - 1);
        pulse_tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (btn_hold !== 3'b001) begin
                errors++;
                $display("FAIL hold_tick_same_edge: cycle %0d got %b, required 001", ncyc, btn_hold);
            end
            cyc_step();
        end
        pulse_tick();
        checks++;
        if (btn_hold !== 3'b000) begin
            errors++;
            $display("FAIL hold_clear_next_tick: got %b, required 000", btn_hold);
        end
        btn_raw[0] = 1'b0;
        steps(LAT + 3);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [NB-1:0] exp;
        btn_raw[1] = 1'b1; expect_press(3'b010);
        steps(LAT + 2);
        checks++;
        if (btn_level !== 3'b010 || btn_hold !== 3'b010) begin
            errors++;
            $display("FAIL mid_setup: level %b hold %b, required 010/010", btn_level, btn_hold);
        end
        btn_raw[0] = 1'b1;
        steps(3);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_hold} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b, required 0", {btn_level, btn_press, btn_hold});
        end
        sb.delete();
        steps(3);
        c = ncyc; rst = 1'b0; expect_press(3'b011);
        for (int k = 0; k < 10; k++) begin
            cyc_step();
            exp = (ncyc >= c + LAT) ? 3'b011 : 3'b000;
            checks++;
            if (btn_level !== exp) begin
                errors++;
                $display("FAIL reset_repress: cycle %0d got %b, required %b", ncyc, btn_level, exp);
            end
        end
        btn_raw = '0;
        steps(LAT + 3);
        pulse_tick();
    endtask

    task automatic test_simultaneous();
        btn_raw = 3'b111; expect_press(3'b111);
        steps(LAT + 1);
        checks++;
        if (btn_level !== 3'b111 || btn_hold !== 3'b111) begin
            errors++;
            $display("FAIL simul_set: level %b hold %b, required 111/111", btn_level, btn_hold);
        end
        steps(3);
        pulse_tick();
        checks++;
        if (btn_hold !== 3'b000) begin
            errors++;
            $display("FAIL simul_clear: got %b, required 000", btn_hold);
        end
        btn_raw = '0;
        steps(LAT + 3);
        checks++;
        if (btn_level !== 3'b000) begin
            errors++;
            $display("FAIL simul_release: got %b, required 000", btn_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_hold();
        test_reset_mid();
        test_simultaneous();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL press_missing: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
